peripheral_bfm_slave_wb: RTL and testbench

PERIPHERAL_BFM_SLAVE_WB -- requirements
Module: peripheral_bfm_slave_wb

---
 rtl/peripheral_wb_pkg.sv | 39 +++
 rtl/peripheral_bfm_slave_wb.sv | 163 ++++++++++++++++
 tb/tb_peripheral_bfm_slave_wb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 definitions: cycle-type/burst-type encodings, op and cycle
// enums, and the burst address sequencer used by the slave BFM.
package peripheral_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP_4  = 2'b01;
    localparam logic [1:0] BTE_WRAP_8  = 2'b10;
    localparam logic [1:0] BTE_WRAP_16 = 2'b11;

    typedef enum logic {READ = 1'b0, WRITE = 1'b1} op_e;
    typedef enum logic {CLASSIC_CYCLE = 1'b0, BURST_CYCLE = 1'b1} cycle_e;

    // Computed at 64 bits; callers truncate to their address width, which
    // gives the required wrap-around at the top of the address space.
    function automatic logic [63:0] wb_next_adr(input logic [63:0] adr,
                                                input logic [2:0]  cti,
                                                input logic [1:0]  bte,
                                                input int unsigned dw);
        logic [63:0] step;
        logic [63:0] span;
        logic [63:0] nxt;
        step = 64'(dw >> 3);
        span = step << (32'(bte) + 32'd1);
        nxt  = adr;
        if (cti == CTI_INC) begin
            if (bte == BTE_LINEAR)
                nxt = adr + step;
            else
                nxt = (adr & ~(span - 64'd1)) | ((adr + step) & (span - 64'd1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/peripheral_bfm_slave_wb.sv
// Wishbone B3 slave bus-functional model: turns each bus beat into a backend
// request and returns the backend's ack/err (and read data) to the master.
module peripheral_bfm_slave_wb
    import peripheral_wb_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEBUG = 0
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            wb_rty_o,
    output logic            req_valid_o,
    output logic [AW-1:0]   req_adr_o,
    output logic            req_we_o,
    output logic [DW/8-1:0] req_sel_o,
    output logic [DW-1:0]   req_wdat_o,
    output logic            req_burst_o,
    output logic            req_last_o,
    input  logic            rsp_ack_i,
    input  logic            rsp_err_i,
    input  logic [DW-1:0]   rsp_rdat_i
);

    typedef enum logic [1:0] {IDLE, BEAT, RESP, NEXT} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     adr_q, adr_d;
    op_e               op_q, op_d;
    logic [DW/8-1:0]   sel_q, sel_d;
    logic [DW-1:0]     wdat_q, wdat_d;
    logic [2:0]        cti_q, cti_d;
    logic [1:0]        bte_q, bte_d;
    cycle_e            cyc_type_q, cyc_type_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              last_beat;

    assign last_beat = (cti_q == CTI_CLASSIC) || (cti_q == CTI_END);

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        op_d       = op_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        cti_d      = cti_q;
        bte_d      = bte_q;
        cyc_type_d = cyc_type_q;
        dat_d      = dat_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                    adr_d      = wb_adr_i;
                    op_d       = wb_we_i ? WRITE : READ;
                    sel_d      = wb_sel_i;
                    wdat_d     = wb_dat_i;
                    cti_d      = wb_cti_i;
                    bte_d      = wb_bte_i;
                    cyc_type_d = (wb_cti_i == CTI_CONST || wb_cti_i == CTI_INC)
                                 ? BURST_CYCLE : CLASSIC_CYCLE;
                    state_d    = BEAT;
                end
            end
            BEAT: begin
                // A dropped cycle outranks any response arriving in the same clock.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (rsp_err_i) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (rsp_ack_i) begin
                    ack_d   = 1'b1;
                    dat_d   = (op_q == READ) ? rsp_rdat_i : '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!wb_cyc_i || err_q || last_beat)
                    state_d = IDLE;
                else
                    state_d = NEXT;
            end
            NEXT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (wb_stb_i) begin
                    sel_d   = wb_sel_i;
                    wdat_d  = wb_dat_i;
                    cti_d   = wb_cti_i;
                    adr_d   = AW'(wb_next_adr(64'(adr_q), cti_q, bte_q, DW));
                    state_d = BEAT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            op_q       <= READ;
            sel_q      <= '0;
            wdat_q     <= '0;
            cti_q      <= '0;
            bte_q      <= '0;
            cyc_type_q <= CLASSIC_CYCLE;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            op_q       <= op_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            cti_q      <= cti_d;
            bte_q      <= bte_d;
            cyc_type_q <= cyc_type_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;
    assign wb_err_o    = err_q;
    assign wb_rty_o    = 1'b0;
    assign req_valid_o = (state_q == BEAT);
    assign req_adr_o   = adr_q;
    assign req_we_o    = (op_q == WRITE);
    assign req_sel_o   = sel_q;
    assign req_wdat_o  = wdat_q;
    assign req_burst_o = (cyc_type_q == BURST_CYCLE);
    assign req_last_o  = (state_q == BEAT) && last_beat;

    if (DEBUG != 0) begin : g_debug
        always_ff @(posedge wb_clk) begin
            if (wb_rst && state_q == BEAT && wb_cyc_i && (rsp_ack_i || rsp_err_i))
                $display("%0t wb_slave %s adr=%h dat=%h sel=%b%s", $time,
                         (op_q == WRITE) ? "WR" : "RD", adr_q,
                         (op_q == WRITE) ? wdat_q : rsp_rdat_i, sel_q,
                         rsp_err_i ? " err" : "");
        end
    end

endmodule

// File: tb/tb_peripheral_bfm_slave_wb.sv
// Scoreboard bench for the Wishbone slave BFM: classic, burst, error, abort
// and reset-mid-burst traffic against a scripted backend.
module tb_peripheral_bfm_slave_wb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   wb_adr_i;
    logic [DW-1:0]   wb_dat_i;
    logic [DW/8-1:0] wb_sel_i;
    logic            wb_we_i;
    logic            wb_cyc_i;
    logic            wb_stb_i;
    logic [2:0]      wb_cti_i;
    logic [1:0]      wb_bte_i;
    logic [DW-1:0]   wb_dat_o;
    logic            wb_ack_o;
    logic            wb_err_o;
    logic            wb_rty_o;
    logic            req_valid_o;
    logic [AW-1:0]   req_adr_o;
    logic            req_we_o;
    logic [DW/8-1:0] req_sel_o;
    logic [DW-1:0]   req_wdat_o;
    logic            req_burst_o;
    logic            req_last_o;
    logic            rsp_ack_i;
    logic            rsp_err_i;
    logic [DW-1:0]   rsp_rdat_i;

    peripheral_bfm_slave_wb #(.AW(AW), .DW(DW), .DEBUG(0)) dut (
        .wb_clk(clk), .wb_rst(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .wb_rty_o(wb_rty_o),
        .req_valid_o(req_valid_o), .req_adr_o(req_adr_o), .req_we_o(req_we_o),
        .req_sel_o(req_sel_o), .req_wdat_o(req_wdat_o),
        .req_burst_o(req_burst_o), .req_last_o(req_last_o),
        .rsp_ack_i(rsp_ack_i), .rsp_err_i(rsp_err_i), .rsp_rdat_i(rsp_rdat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t exp_q[$];
    logic prev_hit = 1'b0;

    // Response monitor: every ack/err must match the oldest expectation.
    always @(negedge clk) begin
        rsp_t e;
        if (prev_hit)
            check("resp_one_cycle", {wb_ack_o, wb_err_o}, 2'b00);
        prev_hit = wb_ack_o | wb_err_o;
        if (wb_ack_o | wb_err_o) begin
            check("ack_err_exclusive", wb_ack_o & wb_err_o, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("resp_is_err", wb_err_o, e.err);
                if (!e.err)
                    check("resp_data", wb_dat_o, e.dat);
            end
        end
    end

    task automatic do_beat(input string tag, input logic [31:0] eadr, input logic ewe,
                           input logic [3:0] esel, input logic [31:0] ewdat,
                           input logic elast, input logic eburst, input int lat,
                           input logic use_err, input logic [31:0] rdat);
        rsp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_valid_o) begin
            check({tag, "_req_timeout"}, 1'b0, 1'b1);
            return;
        end
        check({tag, "_adr"}, req_adr_o, eadr);
        check({tag, "_we"}, req_we_o, ewe);
        check({tag, "_sel"}, req_sel_o, esel);
        if (ewe)
            check({tag, "_wdat"}, req_wdat_o, ewdat);
        check({tag, "_last"}, req_last_o, elast);
        check({tag, "_burst"}, req_burst_o, eburst);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check({tag, "_wait_quiet"}, {wb_ack_o, wb_err_o}, 2'b00);
        end
        if (use_err) rsp_err_i = 1'b1;
        else begin
            rsp_ack_i  = 1'b1;
            rsp_rdat_i = rdat;
        end
        e.err = use_err;
        e.dat = ewe ? 32'h0 : rdat;
        exp_q.push_back(e);
        @(negedge clk);
        rsp_ack_i  = 1'b0;
        rsp_err_i  = 1'b0;
        rsp_rdat_i = $urandom;
        check({tag, "_resp_level"}, use_err ? wb_err_o : wb_ack_o, 1'b1);
    endtask

    task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input logic [2:0] cti, input logic [1:0] bte);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_adr_i = adr;
        wb_we_i  = we;
        wb_sel_i = sel;
        wb_dat_i = dat;
        wb_cti_i = cti;
        wb_bte_i = bte;
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, wb_ack_o, 1'b0);
        check({tag, "_err"}, wb_err_o, 1'b0);
        check({tag, "_dat"}, wb_dat_o, 32'h0);
        check({tag, "_rty"}, wb_rty_o, 1'b0);
        check({tag, "_valid"}, req_valid_o, 1'b0);
        check({tag, "_radr"}, req_adr_o, 32'h0);
        check({tag, "_rwe"}, req_we_o, 1'b0);
        check({tag, "_rsel"}, req_sel_o, 4'h0);
        check({tag, "_rwdat"}, req_wdat_o, 32'h0);
        check({tag, "_rburst"}, req_burst_o, 1'b0);
        check({tag, "_rlast"}, req_last_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_bus();
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cti_i = '0; wb_bte_i = '0;
        rsp_ack_i = 1'b0; rsp_err_i = 1'b0; rsp_rdat_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Classic write, backend answers after 2 wait cycles
        drive(32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 3'b000, 2'b00);
        do_beat("cw", 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 2, 1'b0, 32'h0);
        idle_bus();
        @(negedge clk);
        check("cw_idle_valid", req_valid_o, 1'b0);
        check("cw_dat_zero", wb_dat_o, 32'h0);

        // Classic read; strobe held through ack must not start a new request
        drive(32'h20, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00);
        do_beat("cr", 32'h20, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1, 1'b0, 32'h12345678);
        @(negedge clk);
        check("cr_no_reaccept", req_valid_o, 1'b0);
        check("cr_dat_hold", wb_dat_o, 32'h12345678);
        idle_bus();
        @(negedge clk);
        check("cr_still_idle", req_valid_o, 1'b0);

        // Wrap-4 incrementing read burst starting at 0x0C
        drive(32'h0C, 1'b0, 4'h1, 32'h0, 3'b010, 2'b01);
        do_beat("b0", 32'h0C, 1'b0, 4'h1, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'hA0A0A0A0);
        drive(32'h00, 1'b0, 4'h2, 32'h0, 3'b010, 2'b01);
        do_beat("b1", 32'h00, 1'b0, 4'h2, 32'h0, 1'b0, 1'b1, 1, 1'b0, 32'hA1A1A1A1);
        drive(32'h04, 1'b0, 4'h4, 32'h0, 3'b010, 2'b01);
        do_beat("b2", 32'h04, 1'b0, 4'h4, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'hA2A2A2A2);
        drive(32'h08, 1'b0, 4'h8, 32'h0, 3'b111, 2'b01);
        do_beat("b3", 32'h08, 1'b0, 4'h8, 32'h0, 1'b1, 1'b1, 3, 1'b0, 32'hA3A3A3A3);
        idle_bus();
        @(negedge clk);
        check("b_dat_hold", wb_dat_o, 32'hA3A3A3A3);

        // Error on first burst beat ends the burst; next request is a fresh capture
        drive(32'h40, 1'b0, 4'hF, 32'h0, 3'b010, 2'b00);
        do_beat("er", 32'h40, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 1, 1'b1, 32'h0);
        drive(32'h100, 1'b0, 4'hF, 32'h0, 3'b000, 2'b00);
        do_beat("er_fresh", 32'h100, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'hCAFE0001);
        idle_bus();
        @(negedge clk);

        // Cycle dropped while a request is pending; a same-cycle ack is ignored
        drive(32'h30, 1'b1, 4'h3, 32'h55AA55AA, 3'b000, 2'b00);
        @(negedge clk);
        check("ab_valid", req_valid_o, 1'b1);
        idle_bus();
        rsp_ack_i = 1'b1;
        @(negedge clk);
        rsp_ack_i = 1'b0;
        check("ab_dropped", req_valid_o, 1'b0);
        check("ab_no_ack", wb_ack_o, 1'b0);
        repeat (3) @(negedge clk);

        // Reset asserted in the middle of a linear write burst
        drive(32'h80, 1'b1, 4'hF, 32'h11111111, 3'b010, 2'b00);
        do_beat("rb0", 32'h80, 1'b1, 4'hF, 32'h11111111, 1'b0, 1'b1, 0, 1'b0, 32'h0);
        drive(32'h84, 1'b1, 4'hC, 32'h22222222, 3'b010, 2'b00);
        @(negedge clk);
        @(negedge clk);
        check("rb1_valid", req_valid_o, 1'b1);
        check("rb1_adr", req_adr_o, 32'h84);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst_n = 1'b1;
        idle_bus();
        @(negedge clk);
        drive(32'h50, 1'b1, 4'hF, 32'h600DF00D, 3'b000, 2'b00);
        do_beat("post_rst", 32'h50, 1'b1, 4'hF, 32'h600DF00D, 1'b1, 1'b0, 1, 1'b0, 32'h0);
        idle_bus();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
